// File: rtl/glcd_write_arbiter.sv
// Two-requester write arbiter for a dual-controller 128x64 graphic LCD: power-on init,
// half select, cached page/column command insertion, every bus phase paced by a divided tick.
module glcd_write_arbiter #(
    parameter int TICK_DIV   = 32768,
    parameter int RST_TICKS  = 2,
    parameter int POWER_WAIT = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    input  logic [2:0] req0_page,
    input  logic [6:0] req0_col,
    input  logic [7:0] req0_data,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [2:0] req1_page,
    input  logic [6:0] req1_col,
    input  logic [7:0] req1_data,
    output logic       req1_ready,
    output logic       busy,
    output logic       lcd_e,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       cs1,
    output logic       cs2,
    output logic       lcd_reset,
    output logic [7:0] lcd_data
);

    localparam int            TW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [15:0]   RST_LAST  = 16'(RST_TICKS - 1);
    localparam logic [15:0]   PWR_LAST  = 16'(POWER_WAIT - 1);

    typedef enum logic [2:0] {
        S_RST_HOLD, S_PWR_WAIT, S_INIT, S_IDLE, S_PAGE_CMD, S_COL_CMD, S_DATA_WR
    } state_t;

    state_t          state_q;
    logic [TW-1:0]   tick_cnt_q, tick_cnt_d;
    logic            tick_s;
    logic            phase_q;
    logic [15:0]     wait_q;
    logic [1:0]      init_idx_q;
    logic [1:0][2:0] cache_page_q;
    logic [1:0][5:0] cache_col_q;
    logic [1:0]      cache_vld_q;
    logic            last_q, gnt_q;
    logic [2:0]      page_q;
    logic [6:0]      col_q;
    logic [7:0]      data_q;
    logic            e_q, rs_q, cs1_q, cs2_q, lcd_reset_q, ready0_q, ready1_q, busy_q;
    logic [7:0]      lcd_data_q;

    logic            win1_s, h_s, sel_h_s, sel_page_miss_s, sel_col_miss_s, col_miss_s;
    logic [2:0]      sel_page_s;
    logic [6:0]      sel_col_s;
    logic [7:0]      sel_data_s;
    logic [5:0]      col_inc_s;

    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        case (idx)
            2'd0:    init_cmd = 8'h3F;
            2'd1:    init_cmd = 8'hB8;
            2'd2:    init_cmd = 8'h40;
            2'd3:    init_cmd = 8'hC0;
            default: init_cmd = 8'h3F;
        endcase
    endfunction

    // Tick generation, arbitration choice and cache hit/miss decode
    always_comb begin
        tick_s          = (tick_cnt_q == TICK_LAST);
        tick_cnt_d      = tick_s ? '0 : tick_cnt_q + TW'(1);
        win1_s          = req1_valid & (~req0_valid | ~last_q);
        sel_page_s      = gnt_q ? req1_page : req0_page;
        sel_col_s       = gnt_q ? req1_col  : req0_col;
        sel_data_s      = gnt_q ? req1_data : req0_data;
        sel_h_s         = sel_col_s[6];
        sel_page_miss_s = ~cache_vld_q[sel_h_s] | (cache_page_q[sel_h_s] != sel_page_s);
        sel_col_miss_s  = ~cache_vld_q[sel_h_s] | (cache_col_q[sel_h_s] != sel_col_s[5:0]);
        h_s             = col_q[6];
        col_miss_s      = ~cache_vld_q[h_s] | (cache_col_q[h_s] != col_q[5:0]);
        col_inc_s       = col_q[5:0] + 6'd1;
    end

    // Main controller: reset/init sequencing, grant/latch, command insertion and bus phases
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_RST_HOLD;
            tick_cnt_q   <= '0;
            phase_q      <= 1'b0;
            wait_q       <= 16'd0;
            init_idx_q   <= 2'd0;
            cache_page_q <= '0;
            cache_col_q  <= '0;
            cache_vld_q  <= 2'b00;
            last_q       <= 1'b1;
            gnt_q        <= 1'b0;
            page_q       <= 3'd0;
            col_q        <= 7'd0;
            data_q       <= 8'd0;
            e_q          <= 1'b0;
            rs_q         <= 1'b0;
            cs1_q        <= 1'b0;
            cs2_q        <= 1'b0;
            lcd_reset_q  <= 1'b0;
            lcd_data_q   <= 8'd0;
            ready0_q     <= 1'b0;
            ready1_q     <= 1'b0;
            busy_q       <= 1'b1;
        end else begin
            tick_cnt_q <= tick_cnt_d;
            ready0_q   <= 1'b0;
            ready1_q   <= 1'b0;
            case (state_q)
                S_RST_HOLD: begin
                    if (tick_s) begin
                        if (wait_q == RST_LAST) begin
                            lcd_reset_q <= 1'b1;
                            wait_q      <= 16'd0;
                            state_q     <= S_PWR_WAIT;
                        end else begin
                            wait_q <= wait_q + 16'd1;
                        end
                    end
                end
                // The final wait tick already opens the first init command
                S_PWR_WAIT: begin
                    if (tick_s) begin
                        if (wait_q == PWR_LAST) begin
                            wait_q     <= 16'd0;
                            e_q        <= 1'b1;
                            cs1_q      <= 1'b1;
                            cs2_q      <= 1'b1;
                            rs_q       <= 1'b0;
                            lcd_data_q <= init_cmd(2'd0);
                            init_idx_q <= 2'd0;
                            phase_q    <= 1'b1;
                            state_q    <= S_INIT;
                        end else begin
                            wait_q <= wait_q + 16'd1;
                        end
                    end
                end
                S_INIT: begin
                    if (tick_s) begin
                        if (!phase_q) begin
                            e_q        <= 1'b1;
                            cs1_q      <= 1'b1;
                            cs2_q      <= 1'b1;
                            rs_q       <= 1'b0;
                            lcd_data_q <= init_cmd(init_idx_q);
                            phase_q    <= 1'b1;
                        end else begin
                            e_q     <= 1'b0;
                            phase_q <= 1'b0;
                            if (init_idx_q == 2'd3) begin
                                cache_page_q <= '0;
                                cache_col_q  <= '0;
                                cache_vld_q  <= 2'b11;
                                busy_q       <= 1'b0;
                                state_q      <= S_IDLE;
                            end else begin
                                init_idx_q <= init_idx_q + 2'd1;
                            end
                        end
                    end
                end
                // A grant cycle (ready high) is followed by the latch of the granted request
                S_IDLE: begin
                    if (ready0_q || ready1_q) begin
                        page_q  <= sel_page_s;
                        col_q   <= sel_col_s;
                        data_q  <= sel_data_s;
                        busy_q  <= 1'b1;
                        phase_q <= 1'b0;
                        state_q <= sel_page_miss_s ? S_PAGE_CMD :
                                   (sel_col_miss_s ? S_COL_CMD : S_DATA_WR);
                    end else if (req0_valid || req1_valid) begin
                        ready0_q <= ~win1_s;
                        ready1_q <= win1_s;
                        gnt_q    <= win1_s;
                        last_q   <= win1_s;
                    end else begin
                        gnt_q <= gnt_q;
                    end
                end
                S_PAGE_CMD: begin
                    if (tick_s) begin
                        if (!phase_q) begin
                            e_q        <= 1'b1;
                            cs1_q      <= ~h_s;
                            cs2_q      <= h_s;
                            rs_q       <= 1'b0;
                            lcd_data_q <= {5'b10111, page_q};
                            phase_q    <= 1'b1;
                        end else begin
                            e_q               <= 1'b0;
                            phase_q           <= 1'b0;
                            cache_page_q[h_s] <= page_q;
                            state_q           <= col_miss_s ? S_COL_CMD : S_DATA_WR;
                        end
                    end
                end
                S_COL_CMD: begin
                    if (tick_s) begin
                        if (!phase_q) begin
                            e_q        <= 1'b1;
                            cs1_q      <= ~h_s;
                            cs2_q      <= h_s;
                            rs_q       <= 1'b0;
                            lcd_data_q <= {2'b01, col_q[5:0]};
                            phase_q    <= 1'b1;
                        end else begin
                            e_q              <= 1'b0;
                            phase_q          <= 1'b0;
                            cache_col_q[h_s] <= col_q[5:0];
                            state_q          <= S_DATA_WR;
                        end
                    end
                end
                // Controller auto-increments its column after each data byte, wrapping 63->0
                S_DATA_WR: begin
                    if (tick_s) begin
                        if (!phase_q) begin
                            e_q        <= 1'b1;
                            cs1_q      <= ~h_s;
                            cs2_q      <= h_s;
                            rs_q       <= 1'b1;
                            lcd_data_q <= data_q;
                            phase_q    <= 1'b1;
                        end else begin
                            e_q              <= 1'b0;
                            phase_q          <= 1'b0;
                            cache_col_q[h_s] <= col_inc_s;
                            busy_q           <= 1'b0;
                            state_q          <= S_IDLE;
                        end
                    end
                end
                default: begin
                    state_q <= S_RST_HOLD;
                end
            endcase
        end
    end

    assign req0_ready = ready0_q;
    assign req1_ready = ready1_q;
    assign busy       = busy_q;
    assign lcd_e      = e_q;
    assign lcd_rs     = rs_q;
    assign lcd_rw     = 1'b0;
    assign cs1        = cs1_q;
    assign cs2        = cs2_q;
    assign lcd_reset  = lcd_reset_q;
    assign lcd_data   = lcd_data_q;

endmodule

// File: tb/tb_glcd_write_arbiter.sv
// Directed bench for glcd_write_arbiter: init sequence, cached command insertion,
// arbitration fairness and mid-transaction reset, with a bus monitor logging each strobe.
module tb_glcd_write_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0_valid = 1'b0, req1_valid = 1'b0;
    logic [2:0] req0_page = 3'd0, req1_page = 3'd0;
    logic [6:0] req0_col = 7'd0, req1_col = 7'd0;
    logic [7:0] req0_data = 8'd0, req1_data = 8'd0;
    logic       req0_ready, req1_ready, busy;
    logic       lcd_e, lcd_rs, lcd_rw, cs1, cs2, lcd_reset;
    logic [7:0] lcd_data;

    int          n_chk = 0;
    int          n_err = 0;
    logic [10:0] txq[$];
    int          hiq[$];
    int          loq[$];

    glcd_write_arbiter #(.TICK_DIV(4), .RST_TICKS(2), .POWER_WAIT(4)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_page(req0_page), .req0_col(req0_col),
        .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_page(req1_page), .req1_col(req1_col),
        .req1_data(req1_data), .req1_ready(req1_ready),
        .busy(busy), .lcd_e(lcd_e), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
        .cs1(cs1), .cs2(cs2), .lcd_reset(lcd_reset), .lcd_data(lcd_data)
    );

    always #5 clk = ~clk;

    function automatic logic [10:0] enc(input logic rs, input logic c1, input logic c2,
                                        input logic [7:0] d);
        return {rs, c1, c2, d};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
        end
    endtask

    // Bus monitor: logs {rs,cs1,cs2,data} at each strobe rise plus high/low run lengths
    initial begin
        logic prev_e;
        int   hi_cnt, lo_cnt;
        bit   have_fall;
        prev_e = 1'b0; hi_cnt = 0; lo_cnt = 0; have_fall = 1'b0;
        forever begin
            @(negedge clk);
            if (lcd_e === 1'b1 && prev_e !== 1'b1) begin
                txq.push_back(enc(lcd_rs, cs1, cs2, lcd_data));
                if (have_fall) loq.push_back(lo_cnt);
                hi_cnt = 1;
            end else if (lcd_e === 1'b1) begin
                hi_cnt++;
            end else if (prev_e === 1'b1) begin
                hiq.push_back(hi_cnt);
                have_fall = 1'b1;
                lo_cnt = 1;
            end else begin
                lo_cnt++;
            end
            prev_e = lcd_e;
        end
    end

    task automatic reset_and_init(input string tag);
        int n;
        logic [7:0] icmd[4];
        icmd[0] = 8'h3F; icmd[1] = 8'hB8; icmd[2] = 8'h40; icmd[3] = 8'hC0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq({tag, "_rstvals"},
                 {lcd_e, lcd_rs, lcd_rw, cs1, cs2, lcd_reset, req0_ready, req1_ready, busy, lcd_data},
                 {9'b000000001, 8'h00});
        n = 0;
        while (lcd_reset !== 1'b1 && n < 100) begin n++; @(negedge clk); end
        check_eq({tag, "_rstlow"}, n, 8);
        txq.delete(); hiq.delete(); loq.delete();
        n = 0;
        while (lcd_e !== 1'b1 && n < 100) begin n++; @(negedge clk); end
        check_eq({tag, "_pwrwait"}, n, 16);
        n = 0;
        while (busy !== 1'b0 && n < 200) begin n++; @(negedge clk); end
        check_eq({tag, "_initdone"}, busy, 0);
        check_eq({tag, "_ncmds"}, txq.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (txq.size() > i) check_eq($sformatf("%s_cmd%0d", tag, i), txq[i], enc(1'b0, 1'b1, 1'b1, icmd[i]));
            if (hiq.size() > i) check_eq($sformatf("%s_ehi%0d", tag, i), hiq[i], 4);
        end
        check_eq({tag, "_nlo"}, (loq.size() >= 3) ? 1 : 0, 1);
        for (int i = 0; i < 3; i++) begin
            if (loq.size() >= 3) check_eq($sformatf("%s_elo%0d", tag, i), loq[loq.size() - 3 + i], 4);
        end
        txq.delete();
    endtask

    task automatic do_write(input string tag, input bit who, input logic [2:0] pg,
                            input logic [6:0] cl, input logic [7:0] dt, input int nexp,
                            input logic [10:0] x0, input logic [10:0] x1, input logic [10:0] x2);
        int k;
        logic [10:0] xa[3];
        xa[0] = x0; xa[1] = x1; xa[2] = x2;
        if (who) begin
            req1_valid = 1'b1; req1_page = pg; req1_col = cl; req1_data = dt;
        end else begin
            req0_valid = 1'b1; req0_page = pg; req0_col = cl; req0_data = dt;
        end
        k = 0;
        while ((who ? req1_ready : req0_ready) !== 1'b1 && k < 200) begin @(negedge clk); k++; end
        check_eq({tag, "_grant"}, {req1_ready, req0_ready}, who ? 2'b10 : 2'b01);
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        check_eq({tag, "_rdy1clk"}, {req1_ready, req0_ready, busy}, 3'b001);
        k = 0;
        while (busy !== 1'b0 && k < 200) begin @(negedge clk); k++; end
        check_eq({tag, "_done"}, busy, 0);
        check_eq({tag, "_ntx"}, txq.size(), nexp);
        for (int i = 0; i < nexp; i++) begin
            if (txq.size() > i) check_eq($sformatf("%s_tx%0d", tag, i), txq[i], xa[i]);
        end
        txq.delete();
    endtask

    initial begin
        int k, viol;
        @(negedge clk);
        reset_and_init("init");

        do_write("c0",   1'b0, 3'd0, 7'd0,  8'hFF, 1, enc(1, 1, 0, 8'hFF), 11'd0, 11'd0);
        do_write("c1",   1'b0, 3'd0, 7'd1,  8'h11, 1, enc(1, 1, 0, 8'h11), 11'd0, 11'd0);
        do_write("c5",   1'b0, 3'd0, 7'd5,  8'h55, 2, enc(0, 1, 0, 8'h45), enc(1, 1, 0, 8'h55), 11'd0);
        do_write("c63",  1'b0, 3'd0, 7'd63, 8'h63, 2, enc(0, 1, 0, 8'h7F), enc(1, 1, 0, 8'h63), 11'd0);
        do_write("wrap", 1'b0, 3'd0, 7'd0,  8'hC0, 1, enc(1, 1, 0, 8'hC0), 11'd0, 11'd0);
        do_write("c64",  1'b0, 3'd0, 7'd64, 8'h64, 1, enc(1, 0, 1, 8'h64), 11'd0, 11'd0);
        do_write("r1c70", 1'b1, 3'd3, 7'd70, 8'h81, 3,
                 enc(0, 0, 1, 8'hBB), enc(0, 0, 1, 8'h46), enc(1, 0, 1, 8'h81));
        do_write("r1c71", 1'b1, 3'd3, 7'd71, 8'h82, 1, enc(1, 0, 1, 8'h82), 11'd0, 11'd0);

        // Both requesters held valid: grants must alternate starting with req0
        req0_page = 3'd0; req0_col = 7'd10; req0_data = 8'hA0;
        req1_page = 3'd0; req1_col = 7'd10; req1_data = 8'hA1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        viol = 0;
        for (int g = 0; g < 3; g++) begin
            k = 0;
            while (!(req0_ready === 1'b1 || req1_ready === 1'b1) && k < 300) begin
                @(negedge clk); k++;
                if (busy === 1'b1 && (req0_ready === 1'b1 || req1_ready === 1'b1)) viol++;
            end
            check_eq($sformatf("alt_grant%0d", g), {req1_ready, req0_ready}, (g == 1) ? 2'b10 : 2'b01);
            @(negedge clk);
            check_eq($sformatf("alt_rdy1clk%0d", g), {req1_ready, req0_ready, busy}, 3'b001);
            if (g == 2) begin req0_valid = 1'b0; req1_valid = 1'b0; end
        end
        k = 0;
        while (busy !== 1'b0 && k < 200) begin @(negedge clk); k++; end
        check_eq("alt_nobusygrant", viol, 0);
        check_eq("alt_ntx", txq.size(), 6);
        if (txq.size() == 6) begin
            check_eq("alt_col0", txq[0], enc(0, 1, 0, 8'h4A));
            check_eq("alt_d0", txq[1], enc(1, 1, 0, 8'hA0));
            check_eq("alt_d1", txq[3], enc(1, 1, 0, 8'hA1));
            check_eq("alt_d2", txq[5], enc(1, 1, 0, 8'hA0));
        end
        txq.delete();

        // Reset while a page command strobe is high
        req0_valid = 1'b1; req0_page = 3'd5; req0_col = 7'd2; req0_data = 8'h55;
        k = 0;
        while (req0_ready !== 1'b1 && k < 200) begin @(negedge clk); k++; end
        @(negedge clk);
        req0_valid = 1'b0;
        k = 0;
        while (lcd_e !== 1'b1 && k < 200) begin @(negedge clk); k++; end
        check_eq("mid_pgcmd", {lcd_e, lcd_rs, cs1, cs2, lcd_data}, {4'b1010, 8'hBD});
        reset_and_init("reinit");
        do_write("post", 1'b0, 3'd0, 7'd0, 8'h5A, 1, enc(1, 1, 0, 8'h5A), 11'd0, 11'd0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
